// File: rtl/fifo_multi.sv
// fifo_multi: multi-lane FIFO with all-or-nothing push/pop acceptance.
// Up to ENQ_W entries are pushed and up to DEQ_W entries popped per cycle.
// Output lanes are first-word fall-through from the head pointer.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear of all entries (overrides push/pop)
//   enq_num, d_in  push request count and data (lane 0 is oldest)
//   enq_ok         push of enq_num entries accepted this cycle
//   deq_num        pop request count
//   deq_ok         pop of deq_num entries accepted this cycle
//   d_out          lane i = entry at head+i, zero when lane is not valid
//   out_valid      lane i valid when count > i
//   count          occupancy; full/empty derived from it
//   err            one-cycle pulse after a rejected nonzero request
module fifo_multi #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [$clog2(ENQ_W+1)-1:0]   enq_num,
    input  logic [ENQ_W*WIDTH-1:0]       d_in,
    output logic                         enq_ok,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_num,
    output logic                         deq_ok,
    output logic [DEQ_W*WIDTH-1:0]       d_out,
    output logic [DEQ_W-1:0]             out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $clog2(ENQ_W + 1);
    localparam int XW = CW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [XW-1:0]    room;
    logic             push_go;
    logic             pop_go;
    logic [CW-1:0]    enq_amt;
    logic [CW-1:0]    deq_amt;

    // Free space includes slots released by an accepted pop in the same cycle.
    always_comb begin
        deq_ok  = XW'(deq_num) <= XW'(count);
        room    = XW'(DEPTH) - XW'(count) + (deq_ok ? XW'(deq_num) : '0);
        enq_ok  = XW'(enq_num) <= room;
        push_go = enq_ok && !flush;
        pop_go  = deq_ok && !flush;
        enq_amt = push_go ? CW'(enq_num) : '0;
        deq_amt = pop_go  ? CW'(deq_num) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            head  <= head + AW'(deq_amt);
            tail  <= tail + AW'(enq_amt);
            count <= count + enq_amt - deq_amt;
            err   <= ((enq_num != '0) && !enq_ok) || ((deq_num != '0) && !deq_ok);
        end
    end

    // Storage array carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_go) begin
            for (int unsigned i = 0; i < ENQ_W; i++) begin
                if (EW'(i) < enq_num) begin
                    mem[tail + AW'(i)] <= d_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
        d_out = '0;
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            out_valid[i] = count > CW'(i);
            if (out_valid[i]) begin
                d_out[i*WIDTH +: WIDTH] = mem[head + AW'(i)];
            end
        end
    end

endmodule

// File: doc/fifo_multi.md
# fifo_multi

Multi-lane, parametrised successor to the single-entry FIFO queue. It accepts up to ENQ_W entries and retires up to DEQ_W entries per cycle, with all-or-nothing acceptance, a synchronous flush, and occupancy reporting. It sits between the superscalar fetch/decode stage and dispatch in the out-of-order core, and is the generic buffer for any N-wide producer/consumer pair.

## Interface
- DEPTH, 16, number of entries; power of 2, ≥ 2·max(ENQ_W, DEQ_W)
- WIDTH, 32, bits per entry
- ENQ_W, 2, max entries pushed per cycle (≥1)
- DEQ_W, 2, max entries popped per cycle (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- enq_num  in  $clog2(ENQ_W+1)  number of entries to push this cycle (0..ENQ_W)
- d_in  in  ENQ_W·WIDTH  push data; lane 0 (bits WIDTH-1:0) is oldest
- enq_ok  out  1  push of enq_num entries accepted this cycle
- deq_num  in  $clog2(DEQ_W+1)  number of entries to pop this cycle (0..DEQ_W)
- deq_ok  out  1  pop of deq_num entries accepted this cycle
- d_out  out  DEQ_W·WIDTH  lane i = entry at head+i (first-word fall-through)
- out_valid  out  DEQ_W  lane i valid iff count > i
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- err  out  1  one-cycle pulse: a nonzero push or pop was rejected last cycle

## Operation
- Storage: DEPTH×WIDTH array, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, count register. The array is not reset.
- Pop accept: deq_ok = (deq_num ≤ count). Popping never sees entries pushed in the same cycle.
- Push accept: enq_ok = (enq_num ≤ DEPTH − count + (deq_ok ? deq_num : 0)). Slots freed by a same-cycle accepted pop are reusable; a full FIFO with deq_num ≥ enq_num accepts both.
- Acceptance is all-or-nothing. When rejected: no entries move, pointers and count hold, and err pulses next cycle (only if the rejected num was nonzero).
- A request with num = 0 always reports ok = 1 and has no effect.
- On an accepted push: lanes 0..enq_num−1 are written to tail..tail+enq_num−1 mod DEPTH, and tail advances by enq_num. Lanes ≥ enq_num are ignored.
- On an accepted pop: head advances by deq_num mod DEPTH.
- Next count = count + accepted enq_num − accepted deq_num.
- d_out lane i = mem[(head+i) mod DEPTH] when out_valid[i], else 0.
- flush has top priority over push and pop in the same cycle. The next cycle has head = tail = 0, count = 0, and err = 0. enq_ok and deq_ok are still computed combinationally but have no effect.
- Requests with enq_num > ENQ_W or deq_num > DEQ_W are illegal. Behaviour is undefined and the bench asserts against them.

## Timing
- Reset (rst_n = 0, asynchronous, any time including mid-operation) gives, immediately: count = 0, empty = 1, full = 0, out_valid = 0, d_out = 0, err = 0, head = tail = 0. Stored data is lost. The first accepted push is possible on the first rising edge with rst_n = 1.
- enq_ok and deq_ok are combinational from enq_num, deq_num and the registered count. Paths: deq_num → enq_ok and deq_num → deq_ok.
- Push-to-visible latency is 1 cycle: data pushed at edge k appears on d_out lane 0 after edge k when the FIFO was empty.
- count, full, empty, out_valid and err are all registered-state derived, updating one cycle after the request edge.
- No combinational path from d_in to d_out.

## Test plan
- Reset, then push 3 single entries (11111111, 22222222, 33333333), then pop one per cycle → d_out lane 0 shows 11111111, then 22222222, then 33333333. empty = 1 after the third pop.
- Push 2/cycle until count = 16 → full = 1. Push enq_num = 1 with deq_num = 0 → enq_ok = 0, err = 1 next cycle, count stays 16. Pop deq_num = 2 with enq_num = 2 → both ok, full stays 1, and the order of the popped data is preserved.
- When empty, pop deq_num = 1 → deq_ok = 0, err pulses, count stays 0. With count = 1, pop deq_num = 2 → rejected, and the single entry remains in place.
- Wrap-around: push 5 (values 30..34), pop 4, then push 15 (values 40..54, 2/cycle with a final 1) → full = 1. Draining yields 34, 40..54 in order across the pointer wrap, with out_valid tracking count at each step.
- With count = 7, assert flush together with enq_num = 2 and deq_num = 2 → next cycle count = 0, empty = 1, out_valid = 0, err = 0. A subsequent push of A5A5A5A5 appears on lane 0.
- With 3 entries present, pull rst_n low between edges → empty = 1 and count = 0 before the next edge. Release rst_n, push 1, and the entry is visible after 1 cycle.
